// File: rtl/clint_mh.sv
// rtl/clint_mh.sv - multi-hart core-local interruptor with shared mtime and RTC divider
module clint_mh #(
    parameter int          HARTS     = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          CLK_FREQ  = 1000000000,
    parameter int          RTC_FREQ  = 32768
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_rdata,
    output logic             mem_ready,
    output logic [HARTS-1:0] msip,
    output logic [HARTS-1:0] mtip
);

    localparam logic [31:0] DIV = 32'((CLK_FREQ / RTC_FREQ) / 2 - 1);
    localparam logic [4:0]  NH  = 5'(HARTS);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    logic [31:0] div_cnt;
    logic        rtc;
    logic        rtc_d;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp [HARTS];
    logic [HARTS-1:0] msip_r;

    logic [31:0] off;
    logic        msip_sel;
    logic        cmp_sel;
    logic        mtime_sel;
    logic        acc;
    logic        wr_en;
    logic [31:0] rd_val;

    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    assign off       = mem_addr - BASE_ADDR;
    assign msip_sel  = (off[31:6] == 26'd0) && (off[1:0] == 2'b00) && ({1'b0, off[5:2]} < NH);
    assign cmp_sel   = (off[31:7] == 25'h80) && (off[1:0] == 2'b00) && ({1'b0, off[6:3]} < NH);
    assign mtime_sel = (off[31:3] == 29'h17FF) && (off[1:0] == 2'b00);
    assign acc       = (state == IDLE) && mem_valid;
    assign wr_en     = acc && (mem_wstrb != 4'b0000);
    assign tick      = rtc & ~rtc_d;
    assign msip      = msip_r;

    always_comb begin
        rd_val = 32'd0;
        if (msip_sel) begin
            for (int h = 0; h < HARTS; h++)
                if (off[5:2] == 4'(h)) rd_val = {31'd0, msip_r[h]};
        end
        if (cmp_sel) begin
            for (int h = 0; h < HARTS; h++)
                if (off[6:3] == 4'(h)) rd_val = off[2] ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
        end
        if (mtime_sel) rd_val = off[2] ? mtime[63:32] : mtime[31:0];
    end

    // rtc toggles every DIV+1 clocks; tick marks each rising edge of rtc
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= 32'd0;
            rtc     <= 1'b0;
            rtc_d   <= 1'b0;
        end else begin
            rtc_d <= rtc;
            if (div_cnt == DIV) begin
                div_cnt <= 32'd0;
                rtc     <= ~rtc;
            end else begin
                div_cnt <= div_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        mem_rdata <= rd_val;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= 32'd0;
                end
                default: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    mem_rdata <= 32'd0;
                end
            endcase
        end
    end

    // A bus write to either mtime half suppresses that cycle's increment
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime <= 64'd0;
        end else if (wr_en && mtime_sel && !off[2]) begin
            mtime[31:0] <= wmerge(mtime[31:0], mem_wdata, mem_wstrb);
        end else if (wr_en && mtime_sel && off[2]) begin
            mtime[63:32] <= wmerge(mtime[63:32], mem_wdata, mem_wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msip_r <= '0;
            mtip   <= '0;
            for (int h = 0; h < HARTS; h++)
                mtimecmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            for (int h = 0; h < HARTS; h++) begin
                mtip[h] <= (mtime >= mtimecmp[h]);
                if (wr_en && msip_sel && off[5:2] == 4'(h) && mem_wstrb[0])
                    msip_r[h] <= mem_wdata[0];
                if (wr_en && cmp_sel && off[6:3] == 4'(h)) begin
                    if (off[2])
                        mtimecmp[h][63:32] <= wmerge(mtimecmp[h][63:32], mem_wdata, mem_wstrb);
                    else
                        mtimecmp[h][31:0] <= wmerge(mtimecmp[h][31:0], mem_wdata, mem_wstrb);
                end
            end
        end
    end

endmodule

// File: tb/tb_clint_mh.sv
// tb/tb_clint_mh.sv - scoreboard bench for clint_mh with HARTS=2 and DIV=3
module tb_clint_mh;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [1:0]  msip;
    logic [1:0]  mtip;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];

    clint_mh #(.HARTS(2), .BASE_ADDR(BASE), .CLK_FREQ(8), .RTC_FREQ(1)) dut (
        .clock(clock), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .msip(msip), .mtip(mtip)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1);
    end

    // Reference model: ticks land on edges 5, 13, 21, ... counted from reset release
    int          ecount;
    logic [63:0] mtime_m;
    logic [63:0] cmp_m [0:1];
    logic [1:0]  msip_m;
    logic [1:0]  mtip_m;

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clock or negedge reset) begin
        logic [31:0] mo;
        logic        wr_mt;
        logic        tk;
        if (!reset) begin
            ecount  = 0;
            mtime_m = 64'd0;
            cmp_m[0] = '1;
            cmp_m[1] = '1;
            msip_m  = 2'b00;
            mtip_m  = 2'b00;
        end else begin
            ecount = ecount + 1;
            tk = (ecount >= 5) && (((ecount - 5) % 8) == 0);
            for (int h = 0; h < 2; h++) mtip_m[h] = (mtime_m >= cmp_m[h]);
            wr_mt = 1'b0;
            mo = mem_addr - BASE;
            if (mem_valid && mem_wstrb != 4'b0000) begin
                for (int h = 0; h < 2; h++) begin
                    if (mo == 32'(4*h) && mem_wstrb[0]) msip_m[h] = mem_wdata[0];
                    if (mo == 32'h4000 + 32'(8*h))
                        cmp_m[h][31:0] = bmerge(cmp_m[h][31:0], mem_wdata, mem_wstrb);
                    if (mo == 32'h4004 + 32'(8*h))
                        cmp_m[h][63:32] = bmerge(cmp_m[h][63:32], mem_wdata, mem_wstrb);
                end
                if (mo == 32'hBFF8) begin
                    mtime_m[31:0] = bmerge(mtime_m[31:0], mem_wdata, mem_wstrb);
                    wr_mt = 1'b1;
                end
                if (mo == 32'hBFFC) begin
                    mtime_m[63:32] = bmerge(mtime_m[63:32], mem_wdata, mem_wstrb);
                    wr_mt = 1'b1;
                end
            end
            if (tk && !wr_mt) mtime_m = mtime_m + 64'd1;
        end
    end

    task automatic do_reset();
        @(negedge clock);
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic bus(input logic [15:0] o, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd, output logic r1, output logic r2);
        mem_valid = 1'b1;
        mem_addr  = BASE + {16'd0, o};
        mem_wdata = wd;
        mem_wstrb = ws;
        @(negedge clock);
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        r1 = mem_ready;
        rd = mem_rdata;
        @(negedge clock);
        r2 = mem_ready;
    endtask

    task automatic wait_edge(input int target);
        int k;
        k = 0;
        while (ecount < target && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (ecount < target) begin
            n_cmp++; n_err++;
            $display("FAIL wait_edge timeout: edge=%0d want %0d", ecount, target);
        end
    endtask

    task automatic wait_pre_tick();
        int k;
        k = 0;
        while (!((ecount + 1 >= 5) && (((ecount + 1 - 5) % 8) == 0)) && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (k >= 20) begin
            n_cmp++; n_err++;
            $display("FAIL wait_pre_tick timeout: edge=%0d", ecount);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd, e;
        logic r1, r2;
        @(negedge clock);
        reset = 1'b0;
        #2;
        n_cmp++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'd0 || msip !== 2'b00 || mtip !== 2'b00) begin
            n_err++;
            $display("FAIL reset_outputs: ready=%b rdata=%h msip=%b mtip=%b, want 0 0 00 00",
                     mem_ready, mem_rdata, msip, mtip);
        end
        do_reset();
        exp_q.push_back(32'd0);
        bus(16'hBFF8, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e || r1 !== 1'b1 || r2 !== 1'b0) begin
            n_err++; $display("FAIL reset_mtime: rdata=%h ready=%b%b, want %h ready=10", rd, r1, r2, e);
        end
        exp_q.push_back(32'hFFFF_FFFF);
        bus(16'h4000, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e || r1 !== 1'b1 || r2 !== 1'b0) begin
            n_err++; $display("FAIL reset_cmp0_lo: rdata=%h ready=%b%b, want %h ready=10", rd, r1, r2, e);
        end
        exp_q.push_back(32'hFFFF_FFFF);
        bus(16'h400C, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e || r1 !== 1'b1 || r2 !== 1'b0) begin
            n_err++; $display("FAIL reset_cmp1_hi: rdata=%h ready=%b%b, want %h ready=10", rd, r1, r2, e);
        end
    endtask

    task automatic test_divider();
        logic [31:0] rd, e;
        logic r1, r2;
        do_reset();
        wait_edge(40);
        exp_q.push_back(32'd5);
        bus(16'hBFF8, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e || r1 !== 1'b1 || r2 !== 1'b0) begin
            n_err++; $display("FAIL divider_mtime_lo: rdata=%h ready=%b%b, want %h ready=10", rd, r1, r2, e);
        end
        exp_q.push_back(mtime_m[63:32]);
        bus(16'hBFFC, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin
            n_err++; $display("FAIL divider_mtime_hi: rdata=%h want %h", rd, e);
        end
    endtask

    task automatic test_interrupt();
        logic [31:0] rd;
        logic r1, r2;
        int k;
        do_reset();
        bus(16'h4008, 32'd3, 4'hF, rd, r1, r2);
        bus(16'h400C, 32'd0, 4'hF, rd, r1, r2);
        k = 0;
        while (mtime_m != 64'd3 && k < 100) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (mtip !== 2'b00 || mtip !== mtip_m) begin
            n_err++; $display("FAIL mtip_same_edge: mtip=%b want 00 (model %b)", mtip, mtip_m);
        end
        @(negedge clock);
        n_cmp++;
        if (mtip !== 2'b10 || mtip !== mtip_m) begin
            n_err++; $display("FAIL mtip_assert: mtip=%b want 10 (model %b)", mtip, mtip_m);
        end
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h400C;
        mem_wdata = 32'd1;
        mem_wstrb = 4'hF;
        @(negedge clock);
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        n_cmp++;
        if (mtip !== 2'b10 || mem_ready !== 1'b1) begin
            n_err++; $display("FAIL mtip_hold_on_write: mtip=%b ready=%b want 10 1", mtip, mem_ready);
        end
        @(negedge clock);
        n_cmp++;
        if (mtip !== 2'b00 || mtip !== mtip_m || mem_ready !== 1'b0) begin
            n_err++; $display("FAIL mtip_drop: mtip=%b ready=%b want 00 0", mtip, mem_ready);
        end
    endtask

    task automatic test_msip();
        logic [31:0] rd, e;
        logic r1, r2;
        do_reset();
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'h4;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'b0001;
        @(negedge clock);
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        n_cmp++;
        if (msip !== 2'b10 || msip !== msip_m) begin
            n_err++; $display("FAIL msip_set: msip=%b want 10", msip);
        end
        @(negedge clock);
        exp_q.push_back(32'd1);
        bus(16'h0004, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e || r1 !== 1'b1 || r2 !== 1'b0) begin
            n_err++; $display("FAIL msip1_read: rdata=%h ready=%b%b, want %h ready=10", rd, r1, r2, e);
        end
        exp_q.push_back(32'd0);
        bus(16'h0000, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin
            n_err++; $display("FAIL msip0_read: rdata=%h want %h", rd, e);
        end
        bus(16'h0004, 32'd0, 4'b0010, rd, r1, r2);
        n_cmp++;
        if (msip !== 2'b10 || msip !== msip_m) begin
            n_err++; $display("FAIL msip_partial_strb: msip=%b want 10", msip);
        end
    endtask

    task automatic test_collision();
        logic [31:0] rd, e;
        logic r1, r2;
        do_reset();
        wait_edge(6);
        wait_pre_tick();
        bus(16'hBFF8, 32'h10, 4'hF, rd, r1, r2);
        exp_q.push_back(32'h10);
        bus(16'hBFF8, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e || rd !== mtime_m[31:0]) begin
            n_err++; $display("FAIL collision_write_wins: rdata=%h want %h", rd, e);
        end
        wait_pre_tick();
        @(negedge clock);
        exp_q.push_back(32'h11);
        bus(16'hBFF8, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin
            n_err++; $display("FAIL collision_next_tick: rdata=%h want %h", rd, e);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, e;
        logic r1, r2;
        do_reset();
        bus(16'h4000, 32'd0, 4'hF, rd, r1, r2);
        bus(16'h4004, 32'd0, 4'hF, rd, r1, r2);
        wait_edge(6);
        bus(16'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, r1, r2);
        bus(16'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, r1, r2);
        exp_q.push_back(32'hFFFF_FFFF);
        bus(16'hBFFC, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin
            n_err++; $display("FAIL wrap_pre_hi: rdata=%h want %h", rd, e);
        end
        wait_pre_tick();
        @(negedge clock);
        exp_q.push_back(32'd0);
        bus(16'hBFF8, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin
            n_err++; $display("FAIL wrap_lo: rdata=%h want %h", rd, e);
        end
        exp_q.push_back(32'd0);
        bus(16'hBFFC, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e) begin
            n_err++; $display("FAIL wrap_hi: rdata=%h want %h", rd, e);
        end
        n_cmp++;
        if (mtip[0] !== 1'b1 || mtip !== mtip_m) begin
            n_err++; $display("FAIL wrap_mtip: mtip=%b want x1 (model %b)", mtip, mtip_m);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, e;
        logic r1, r2;
        logic [15:0] offs [3];
        offs[0] = 16'h0008;
        offs[1] = 16'h4010;
        offs[2] = 16'h0100;
        do_reset();
        bus(16'h0008, 32'd1, 4'hF, rd, r1, r2);
        bus(16'h4010, 32'd0, 4'hF, rd, r1, r2);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'd0);
            bus(offs[i], 32'd0, 4'd0, rd, r1, r2);
            e = exp_q.pop_front(); n_cmp++;
            if (rd !== e || r1 !== 1'b1 || r2 !== 1'b0) begin
                n_err++;
                $display("FAIL unmapped_%h: rdata=%h ready=%b%b, want %h ready=10", offs[i], rd, r1, r2, e);
            end
        end
        n_cmp++;
        if (msip !== 2'b00 || mtip !== 2'b00) begin
            n_err++; $display("FAIL unmapped_no_effect: msip=%b mtip=%b want 00 00", msip, mtip);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, e;
        logic r1, r2;
        do_reset();
        bus(16'h0004, 32'd1, 4'hF, rd, r1, r2);
        mem_valid = 1'b1;
        mem_addr  = BASE;
        mem_wdata = 32'd1;
        mem_wstrb = 4'hF;
        #2;
        reset = 1'b0;
        @(negedge clock);
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        n_cmp++;
        if (mem_ready !== 1'b0 || msip !== 2'b00) begin
            n_err++; $display("FAIL reset_before_accept: ready=%b msip=%b want 0 00", mem_ready, msip);
        end
        @(negedge clock);
        reset = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = BASE + 32'hBFF8;
        mem_wstrb = 4'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'd0) begin
            n_err++; $display("FAIL reset_in_resp: ready=%b rdata=%h want 0 0", mem_ready, mem_rdata);
        end
        mem_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        exp_q.push_back(32'hFFFF_FFFF);
        bus(16'h4008, 32'd0, 4'd0, rd, r1, r2);
        e = exp_q.pop_front(); n_cmp++;
        if (rd !== e || r1 !== 1'b1 || r2 !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_cmp: rdata=%h ready=%b%b, want %h ready=10", rd, r1, r2, e);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_interrupt();
        test_msip();
        test_collision();
        test_wrap();
        test_unmapped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clint_mh.md
# clint_mh

Multi-hart core-local interruptor with a parametrised real-time-clock divider: a generalisation of the platform's single-hart timer block to `HARTS` harts. It owns the shared 64-bit `mtime` counter, advanced at `RTC_FREQ` derived from `CLK_FREQ`. It also owns a per-hart `msip` bit and 64-bit `mtimecmp` register, and drives per-hart software and timer interrupt lines to the cores. It sits on the data memory bus at `BASE_ADDR` (platform value 32'h2000000, window 32'hC000).

## Interface
- `HARTS`, 1: number of harts; 1..16.
- `BASE_ADDR`, 32'h2000000: bus base address.
- `CLK_FREQ`, 1000000000: core clock frequency in Hz.
- `RTC_FREQ`, 32768: `mtime` tick frequency in Hz.
- `DIV`, derived as (CLK_FREQ/RTC_FREQ)/2-1: half-period count; must be >= 0.
- `reset`  in  1  asynchronous, active-low reset.
- `clock`  in  1  core clock; all state is on its rising edge.
- `mem_valid`  in  1  request strobe; one-cycle pulse per access.
- `mem_addr`  in  32  byte address, word aligned.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte enables; 0 means read.
- `mem_rdata`  out  32  read data; valid while `mem_ready`=1.
- `mem_ready`  out  1  completion pulse.
- `msip`  out  HARTS  software interrupt per hart.
- `mtip`  out  HARTS  timer interrupt per hart.

## Operation
- Offset: off = mem_addr - BASE_ADDR.
- Address map:
  - msip[h] at 4*h; bit 0 is read/write, bits 31:1 read 0.
  - mtimecmp[h] low word at 16'h4000+8*h; high word at +4.
  - mtime low word at 16'hBFF8; high word at 16'hBFFC.
- Unmapped offsets, including h >= HARTS: reads return 0 and writes are ignored; `mem_ready` still pulses.
- Writes honour `mem_wstrb` per byte. A partial write to msip updates bit 0 only if `wstrb[0]`=1.
- RTC divider:
  - A counter `div_cnt` counts 0..DIV, then wraps to 0 and toggles `rtc`.
  - A rising edge of `rtc` produces a one-cycle `tick`. Result: one tick every 2*(DIV+1) clocks.
- `mtime` increments by 1 on `tick`; 64-bit wrap-around from all-ones to 0.
- A bus write to either `mtime` half in the same cycle as `tick` takes precedence. The written half takes the bus value, and no increment is applied that cycle to either half.
- mtip[h] is registered: mtip[h] <= (mtime >= mtimecmp[h]), unsigned 64-bit compare on the current register values.
- msip[h] drives the register bit directly.
- FSM states:
  - IDLE: the bus request is accepted.
  - RESP: `mem_ready`=1 and `mem_rdata` valid.
  - RESP always returns to IDLE. `mem_valid` during RESP is ignored; masters do not issue back-to-back requests.
- Register writes take effect at the IDLE->RESP clock edge.

## Timing
- Reset (`reset`=0, asynchronous):
  - `mem_ready`=0, `mem_rdata`=0.
  - msip=0, mtip=0, mtime=0.
  - mtimecmp[h]=64'hFFFF_FFFF_FFFF_FFFF, div_cnt=0, rtc=0, FSM=IDLE.
- Reset mid-access: any pending response is dropped and no write is applied after reset.
- Read/write latency: `mem_ready` is asserted exactly one clock after the `mem_valid` cycle, for exactly one cycle.
- Read data:
  - Data is sampled in the `mem_valid` cycle.
  - A read of `mtime` in the same cycle as `tick` returns the pre-increment value.
  - Reading the halves is not atomic; software re-reads the high half.
- Interrupt latency:
  - mtip updates one clock after the compare inputs change.
  - After a `mtimecmp` write, mtip reflects the new value 1 clock after the write edge.
  - msip is visible on the same edge as the write.
- First tick after reset: `rtc` rises at clock edge DIV+1; `mtime`=1 after edge DIV+2.

## Test plan
- Divider: CLK_FREQ=8, RTC_FREQ=1 (DIV=3), idle bus for 40 clocks after reset release -> `mtime` reads 5 (ticks every 8 clocks, first at edge 5).
- Interrupt: HARTS=2, write mtimecmp[1] low=3 and high=0 -> mtip=2'b10 one clock after `mtime` reaches 3, mtip[0] stays 0. Then write mtimecmp[1] high=1 -> mtip[1] drops 1 clock later.
- Software interrupt: write 32'hFFFF_FFFF to offset 4 with wstrb=4'b0001 -> msip=2'b10; readback returns 1. Write with wstrb=4'b0010 -> no change.
- Write/tick collision: write mtime low=32'h10 in the tick cycle -> `mtime`=32'h10 (no +1); the next tick gives 32'h11.
- Wrap-around: write mtime high and low = 32'hFFFF_FFFF, mtimecmp[0]=0 -> after the next tick `mtime`=0 and mtip[0]=1.
- Unmapped and reset cases:
  - Read offset 16'h0008 with HARTS=2 -> rdata 0, `mem_ready` pulses at +1.
  - Assert reset mid-access -> `mem_ready` stays 0 and all registers return to reset values.
